falafel_header_lsu: RTL and testbench
=====================================

// Module: falafel_header_lsu
// PURPOSE
//  Header load/store unit downstream of the allocator control FSM. Accepts one header_req_t
//  (falafel_pkg) at a time and expands it into single-word memory transactions: lock AMO,
//  size/next_addr reads, or header writes. Returns a header_rsp_t when done.
//  At most one memory transaction is outstanding.
// PARAMETERS
//  LOCK_ADDR    64'h0  byte address of the allocator lock word
//  RETRY_DELAY  4      idle cycles between failed LOCK attempts (>=1)
// PORTS
//  clk_i           in   1      clock; all logic on rising edge
//  rst_i           in   1      synchronous, active-high reset
//  req_i           in   struct header_req_t; req_i.val = request valid
//  req_rdy_o       in/out out 1  request accepted when req_i.val && req_rdy_o
//  rsp_o           out  struct header_rsp_t; rsp_o.val = response valid
//  rsp_rdy_i       in   1      response consumed when rsp_o.val && rsp_rdy_i
//  mem_req_val_o   out  1      memory request valid
//  mem_req_rdy_i   in   1      memory accepts request
//  mem_req_we_o    out  1      1 = write, 0 = read (ignored when amo=1)
//  mem_req_amo_o   out  1      atomic swap: write wdata, return old word
//  mem_req_addr_o  out  64     byte address, 8-byte aligned
//  mem_req_wdata_o out  64     write/swap data
//  mem_rsp_val_i   in   1      one-cycle response pulse; every request gets exactly one
//  mem_rsp_rdata_i in   64     read/old data (don't-care for writes)
// BEHAVIOUR
//  Reset: state=IDLE; req_rdy_o=1; rsp_o='0; all mem_req_*_o=0; word index=0; retry ctr=0.
//  Request is registered on acceptance (addr, size, next_addr, op).
//  Word sequence per op (A = req addr, N = A+BLOCK_NEXT_ADDR_OFFSET):
//   LOCK         AMO swap 1 @LOCK_ADDR; old!=0 -> wait RETRY_DELAY cycles, reissue; old==0 -> done
//   UNLOCK       write 0 @LOCK_ADDR
//   LOAD         read @A -> size; read @N -> next_addr
//   UPDATE       write next_addr @N
//   ALLOC_INSERT write size @A
//   FREE_INSERT  write size @A, then write next_addr @N
//   DELETE       write EMPTY_KEY @A, then write EMPTY_KEY @N
//   other enc.   no memory access; respond with echoed header
//  States: IDLE -> MEM_REQ (on accept) -> MEM_WAIT (on mem handshake) ->
//   MEM_REQ (more words) | RETRY (LOCK fail) | RSP (last word); RETRY -> MEM_REQ
//   after RETRY_DELAY cycles; RSP -> IDLE on rsp handshake.
//  req_rdy_o=1 only in IDLE. mem_req_val_o=1 only in MEM_REQ; addr/we/amo/wdata held
//   stable while val && !rdy. mem_rsp_val_i ignored outside MEM_WAIT.
//  Response: rsp_o.val=1 in RSP, held until rsp_rdy_i. LOAD returns {A, read size, read
//   next}; all other ops echo the registered request header. Header fields zero when !val.
//  Latency (zero-wait memory, rsp in cycle after accept of mem req): accept at cycle 0;
//   first mem_req_val_o at cycle 1; rsp_o.val one cycle after last mem_rsp_val_i.
//  Addresses: 64-bit wrap-around add for N; no alignment check (upstream's responsibility).
//  Reset mid-operation: return to IDLE at next edge, drop request, no response; a late
//   mem_rsp_val_i after reset is ignored.
//  Single-master lock semantics rely solely on the memory-side atomic swap.
// TESTING
//  LOAD A=0x1000, mem[0x1000]=0x40, mem[0x1008]=0x2000 -> reads 0x1000 then 0x1008;
//   rsp {addr=0x1000,size=0x40,next=0x2000}, rsp_o.val at cycle 5 with zero-wait memory.
//  LOCK, lock word returns 1,1,0 -> three AMO swaps @LOCK_ADDR wdata=1, gaps of
//   RETRY_DELAY idle cycles between them; one response after third.
//  FREE_INSERT A=0x1000 size=0x80 next=0x3000 -> write 0x1000<=0x80 then 0x1008<=0x3000;
//   DELETE same A -> two writes of 0; UPDATE -> only 0x1008; ALLOC_INSERT -> only 0x1000.
//  mem_req_rdy_i low 5 cycles during LOAD -> mem_req_* stable, no duplicate request.
//  rsp_rdy_i low 10 cycles -> rsp_o held, req_rdy_o=0, new req_i.val not accepted.
//  rst_i pulse in MEM_WAIT, then mem_rsp_val_i -> IDLE, no rsp_o.val, next LOAD correct.

Source files
------------

// File: rtl/falafel_header_lsu.sv
// Header load/store unit behind the allocator control FSM: turns one header request
// into single-word lock/read/write memory transactions and returns one response.
package falafel_pkg;

  localparam logic [63:0] BLOCK_NEXT_ADDR_OFFSET = 64'd8;
  localparam logic [63:0] EMPTY_KEY              = 64'd0;

  typedef enum logic [2:0] {
    HDR_OP_LOCK         = 3'd0,
    HDR_OP_UNLOCK       = 3'd1,
    HDR_OP_LOAD         = 3'd2,
    HDR_OP_UPDATE       = 3'd3,
    HDR_OP_ALLOC_INSERT = 3'd4,
    HDR_OP_FREE_INSERT  = 3'd5,
    HDR_OP_DELETE       = 3'd6,
    HDR_OP_NOP          = 3'd7
  } hdr_op_e;

  typedef struct packed {
    logic        val;
    hdr_op_e     op;
    logic [63:0] addr;
    logic [63:0] size;
    logic [63:0] next_addr;
  } header_req_t;

  typedef struct packed {
    logic        val;
    logic [63:0] addr;
    logic [63:0] size;
    logic [63:0] next_addr;
  } header_rsp_t;

endpackage

module falafel_header_lsu
  import falafel_pkg::*;
#(
  parameter logic [63:0] LOCK_ADDR   = 64'h0,
  parameter int unsigned RETRY_DELAY = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  header_req_t req_i,
  output logic        req_rdy_o,
  output header_rsp_t rsp_o,
  input  logic        rsp_rdy_i,
  output logic        mem_req_val_o,
  input  logic        mem_req_rdy_i,
  output logic        mem_req_we_o,
  output logic        mem_req_amo_o,
  output logic [63:0] mem_req_addr_o,
  output logic [63:0] mem_req_wdata_o,
  input  logic        mem_rsp_val_i,
  input  logic [63:0] mem_rsp_rdata_i
);

  localparam int unsigned CW = (RETRY_DELAY > 1) ? $clog2(RETRY_DELAY) : 1;
  localparam logic [CW-1:0] RETRY_LAST = CW'(RETRY_DELAY - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MEM_REQ  = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_RETRY    = 3'd3,
    ST_RSP      = 3'd4
  } state_e;

  typedef struct packed {
    logic        we;
    logic        amo;
    logic [63:0] addr;
    logic [63:0] wdata;
  } mem_cmd_t;

  // Number of memory words an op touches; zero means respond straight away.
  function automatic logic [1:0] op_words(input hdr_op_e op);
    case (op)
      HDR_OP_LOCK, HDR_OP_UNLOCK, HDR_OP_UPDATE, HDR_OP_ALLOC_INSERT: op_words = 2'd1;
      HDR_OP_LOAD, HDR_OP_FREE_INSERT, HDR_OP_DELETE:                 op_words = 2'd2;
      default:                                                        op_words = 2'd0;
    endcase
  endfunction

  function automatic mem_cmd_t word_cmd(input hdr_op_e op, input logic idx,
                                        input logic [63:0] a, input logic [63:0] sz,
                                        input logic [63:0] nx);
    mem_cmd_t    c;
    logic [63:0] n;
    n = a + BLOCK_NEXT_ADDR_OFFSET;
    c = '0;
    case (op)
      HDR_OP_LOCK: begin
        c.amo = 1'b1; c.addr = LOCK_ADDR; c.wdata = 64'd1;
      end
      HDR_OP_UNLOCK: begin
        c.we = 1'b1; c.addr = LOCK_ADDR; c.wdata = 64'd0;
      end
      HDR_OP_LOAD: c.addr = idx ? n : a;
      HDR_OP_UPDATE: begin
        c.we = 1'b1; c.addr = n; c.wdata = nx;
      end
      HDR_OP_ALLOC_INSERT: begin
        c.we = 1'b1; c.addr = a; c.wdata = sz;
      end
      HDR_OP_FREE_INSERT: begin
        c.we = 1'b1; c.addr = idx ? n : a; c.wdata = idx ? nx : sz;
      end
      HDR_OP_DELETE: begin
        c.we = 1'b1; c.addr = idx ? n : a; c.wdata = EMPTY_KEY;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e      state_q, state_d;
  hdr_op_e     op_q, op_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] size_q, size_d;
  logic [63:0] next_q, next_d;
  logic        word_q, word_d;
  logic [CW-1:0] retry_q, retry_d;
  logic        mreq_val_q, mreq_val_d;
  mem_cmd_t    mreq_cmd_q, mreq_cmd_d;
  header_rsp_t rsp_q, rsp_d;

  // Next-state, request capture, memory command and response construction.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    size_d     = size_q;
    next_d     = next_q;
    word_d     = word_q;
    retry_d    = retry_q;
    mreq_val_d = mreq_val_q;
    mreq_cmd_d = mreq_cmd_q;
    rsp_d      = rsp_q;
    case (state_q)
      ST_IDLE: begin
        if (req_i.val) begin
          op_d   = req_i.op;
          addr_d = req_i.addr;
          size_d = req_i.size;
          next_d = req_i.next_addr;
          word_d = 1'b0;
          if (op_words(req_i.op) == 2'd0) begin
            state_d = ST_RSP;
            rsp_d   = '{val: 1'b1, addr: req_i.addr, size: req_i.size,
                        next_addr: req_i.next_addr};
          end else begin
            state_d    = ST_MEM_REQ;
            mreq_val_d = 1'b1;
            mreq_cmd_d = word_cmd(req_i.op, 1'b0, req_i.addr, req_i.size, req_i.next_addr);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MEM_REQ: begin
        if (mem_req_rdy_i) begin
          mreq_val_d = 1'b0;
          state_d    = ST_MEM_WAIT;
        end else begin
          mreq_val_d = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_rsp_val_i) begin
          // LOAD overwrites the captured header so the response path is shared.
          if (op_q == HDR_OP_LOAD) begin
            if (word_q) next_d = mem_rsp_rdata_i;
            else        size_d = mem_rsp_rdata_i;
          end else begin
            size_d = size_q;
          end
          if ((op_q == HDR_OP_LOCK) && (mem_rsp_rdata_i != 64'd0)) begin
            state_d = ST_RETRY;
            retry_d = '0;
          end else if (word_q || (op_words(op_q) == 2'd1)) begin
            state_d = ST_RSP;
            rsp_d   = '{val: 1'b1, addr: addr_q, size: size_d, next_addr: next_d};
          end else begin
            word_d     = 1'b1;
            state_d    = ST_MEM_REQ;
            mreq_val_d = 1'b1;
            mreq_cmd_d = word_cmd(op_q, 1'b1, addr_q, size_q, next_q);
          end
        end else begin
          state_d = ST_MEM_WAIT;
        end
      end
      ST_RETRY: begin
        if (retry_q == RETRY_LAST) begin
          state_d    = ST_MEM_REQ;
          mreq_val_d = 1'b1;
          mreq_cmd_d = word_cmd(op_q, 1'b0, addr_q, size_q, next_q);
        end else begin
          retry_d = retry_q + CW'(1);
        end
      end
      ST_RSP: begin
        if (rsp_rdy_i) begin
          state_d = ST_IDLE;
          rsp_d   = '0;
        end else begin
          state_d = ST_RSP;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        mreq_val_d = 1'b0;
        rsp_d      = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      op_q       <= HDR_OP_LOCK;
      addr_q     <= 64'd0;
      size_q     <= 64'd0;
      next_q     <= 64'd0;
      word_q     <= 1'b0;
      retry_q    <= '0;
      mreq_val_q <= 1'b0;
      mreq_cmd_q <= '0;
      rsp_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      next_q     <= next_d;
      word_q     <= word_d;
      retry_q    <= retry_d;
      mreq_val_q <= mreq_val_d;
      mreq_cmd_q <= mreq_cmd_d;
      rsp_q      <= rsp_d;
    end
  end

  assign req_rdy_o       = (state_q == ST_IDLE);
  assign rsp_o           = rsp_q;
  assign mem_req_val_o   = mreq_val_q;
  assign mem_req_we_o    = mreq_cmd_q.we;
  assign mem_req_amo_o   = mreq_cmd_q.amo;
  assign mem_req_addr_o  = mreq_cmd_q.addr;
  assign mem_req_wdata_o = mreq_cmd_q.wdata;

endmodule

// File: tb/tb_falafel_header_lsu.sv
// Directed self-checking bench for falafel_header_lsu with a zero-wait memory model.
module tb_falafel_header_lsu;
  import falafel_pkg::*;

  localparam logic [63:0] LA = 64'h0000_0000_0000_0F00;
  localparam int          RD = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  header_req_t req_i;
  logic        req_rdy_o;
  header_rsp_t rsp_o;
  logic        rsp_rdy_i;
  logic        mem_req_val_o, mem_req_rdy_i, mem_req_we_o, mem_req_amo_o;
  logic [63:0] mem_req_addr_o, mem_req_wdata_o;
  logic        mem_rsp_val_i = 1'b0;
  logic [63:0] mem_rsp_rdata_i = 64'd0;

  always #5 clk = ~clk;

  falafel_header_lsu #(.LOCK_ADDR(LA), .RETRY_DELAY(RD)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .req_rdy_o(req_rdy_o),
    .rsp_o(rsp_o), .rsp_rdy_i(rsp_rdy_i),
    .mem_req_val_o(mem_req_val_o), .mem_req_rdy_i(mem_req_rdy_i),
    .mem_req_we_o(mem_req_we_o), .mem_req_amo_o(mem_req_amo_o),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_wdata_o(mem_req_wdata_o),
    .mem_rsp_val_i(mem_rsp_val_i), .mem_rsp_rdata_i(mem_rsp_rdata_i)
  );

  typedef struct { logic amo; logic we; logic [63:0] addr; logic [63:0] wdata; int cyc; } mreq_t;
  typedef struct { logic [63:0] addr; logic [63:0] size; logic [63:0] next_addr; int cyc; } rsp_ev_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          accept_cyc;
  logic        pend      = 1'b0;
  logic        hold_rsp  = 1'b0;
  logic        force_rsp = 1'b0;
  logic [63:0] pend_data = 64'd0;
  logic [63:0] mem [logic [63:0]];
  logic [63:0] lock_seq [$];
  mreq_t       mlog [$];
  rsp_ev_t     rlog [$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mem_answer(input logic amo, input logic we, input logic [63:0] a);
    if (amo) return (lock_seq.size() > 0) ? lock_seq.pop_front() : 64'd0;
    if (we) return 64'd0;
    return mem.exists(a) ? mem[a] : 64'd0;
  endfunction

  // Memory responder and transaction/response logger, evaluated mid-cycle.
  always @(negedge clk) begin
    mem_rsp_val_i   <= pend | force_rsp;
    mem_rsp_rdata_i <= force_rsp ? 64'h0000_0000_0000_BEEF : pend_data;
    pend            <= 1'b0;
    if (mem_req_val_o && mem_req_rdy_i) begin
      mlog.push_back('{mem_req_amo_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o, cyc});
      pend_data <= mem_answer(mem_req_amo_o, mem_req_we_o, mem_req_addr_o);
      pend      <= !hold_rsp;
    end
    if (rsp_o.val && rsp_rdy_i) rlog.push_back('{rsp_o.addr, rsp_o.size, rsp_o.next_addr, cyc});
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic mreq_t mget(input int i);
    mreq_t m;
    m = '{1'bx, 1'bx, 64'hx, 64'hx, -1};
    if (i < mlog.size()) m = mlog[i];
    return m;
  endfunction

  function automatic rsp_ev_t rget(input int i);
    rsp_ev_t r;
    r = '{64'hx, 64'hx, 64'hx, -1};
    if (i < rlog.size()) r = rlog[i];
    return r;
  endfunction

  task automatic check_mw(input string tag, input int i, input logic amo, input logic we,
                          input logic [63:0] a, input logic chk_wd, input logic [63:0] wd);
    mreq_t m;
    m = mget(i);
    check({tag, "_amo"}, {63'd0, m.amo}, {63'd0, amo});
    check({tag, "_we"}, {63'd0, m.we}, {63'd0, we});
    check({tag, "_addr"}, m.addr, a);
    if (chk_wd) check({tag, "_wdata"}, m.wdata, wd);
  endtask

  task automatic check_rsp(input string tag, input logic [63:0] a, input logic [63:0] sz,
                           input logic [63:0] nx);
    rsp_ev_t r;
    r = rget(0);
    check({tag, "_rsp_addr"}, r.addr, a);
    check({tag, "_rsp_size"}, r.size, sz);
    check({tag, "_rsp_next"}, r.next_addr, nx);
  endtask

  task automatic clr_logs();
    mlog.delete();
    rlog.delete();
  endtask

  task automatic send_req(input hdr_op_e op, input logic [63:0] a, input logic [63:0] sz,
                          input logic [63:0] nx);
    int w;
    w = 0;
    @(posedge clk); #1;
    req_i.val = 1'b1; req_i.op = op; req_i.addr = a; req_i.size = sz; req_i.next_addr = nx;
    @(negedge clk);
    while (!req_rdy_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("req_accept", {63'd0, req_rdy_o}, 64'd1);
    accept_cyc = cyc;
    @(posedge clk); #1;
    req_i = '0;
  endtask

  task automatic wait_rsps(input string tag, input int n);
    int w;
    w = 0;
    while (rlog.size() < n && w < 200) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_rsp_cnt"}, rlog.size(), n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_i = 1'b1; req_i = '0; rsp_rdy_i = 1'b1; mem_req_rdy_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("rst_req_rdy", {63'd0, req_rdy_o}, 64'd1);
    check("rst_rsp_val", {63'd0, rsp_o.val}, 64'd0);
    check("rst_mem_val", {63'd0, mem_req_val_o}, 64'd0);
    check("rst_mem_addr", mem_req_addr_o, 64'd0);

    // LOAD with zero-wait memory, including latency
    mem[64'h1000] = 64'h40; mem[64'h1008] = 64'h2000;
    clr_logs();
    send_req(HDR_OP_LOAD, 64'h1000, 64'h0, 64'h0);
    wait_rsps("load", 1);
    check("load_nreq", mlog.size(), 2);
    check_mw("load_w0", 0, 1'b0, 1'b0, 64'h1000, 1'b0, 64'd0);
    check_mw("load_w1", 1, 1'b0, 1'b0, 64'h1008, 1'b0, 64'd0);
    check("load_req_lat", mget(0).cyc - accept_cyc, 64'd1);
    check("load_rsp_lat", rget(0).cyc - accept_cyc, 64'd5);
    check_rsp("load", 64'h1000, 64'h40, 64'h2000);

    // LOCK retried twice before the swap returns 0
    lock_seq = '{64'd1, 64'd1, 64'd0};
    clr_logs();
    send_req(HDR_OP_LOCK, 64'h5000, 64'h11, 64'h22);
    wait_rsps("lock", 1);
    check("lock_nreq", mlog.size(), 3);
    for (int i = 0; i < 3; i++) check_mw("lock_amo", i, 1'b1, 1'b0, LA, 1'b1, 64'd1);
    check("lock_gap1", mget(1).cyc - mget(0).cyc, RD + 2);
    check("lock_gap2", mget(2).cyc - mget(1).cyc, RD + 2);
    check_rsp("lock", 64'h5000, 64'h11, 64'h22);

    clr_logs();
    send_req(HDR_OP_FREE_INSERT, 64'h1000, 64'h80, 64'h3000);
    wait_rsps("free", 1);
    check("free_nreq", mlog.size(), 2);
    check_mw("free_w0", 0, 1'b0, 1'b1, 64'h1000, 1'b1, 64'h80);
    check_mw("free_w1", 1, 1'b0, 1'b1, 64'h1008, 1'b1, 64'h3000);
    check_rsp("free", 64'h1000, 64'h80, 64'h3000);

    clr_logs();
    send_req(HDR_OP_DELETE, 64'h1000, 64'h80, 64'h3000);
    wait_rsps("del", 1);
    check("del_nreq", mlog.size(), 2);
    check_mw("del_w0", 0, 1'b0, 1'b1, 64'h1000, 1'b1, 64'd0);
    check_mw("del_w1", 1, 1'b0, 1'b1, 64'h1008, 1'b1, 64'd0);

    clr_logs();
    send_req(HDR_OP_UPDATE, 64'h1000, 64'h80, 64'h3000);
    wait_rsps("upd", 1);
    check("upd_nreq", mlog.size(), 1);
    check_mw("upd_w0", 0, 1'b0, 1'b1, 64'h1008, 1'b1, 64'h3000);

    clr_logs();
    send_req(HDR_OP_ALLOC_INSERT, 64'h1000, 64'h80, 64'h3000);
    wait_rsps("alloc", 1);
    check("alloc_nreq", mlog.size(), 1);
    check_mw("alloc_w0", 0, 1'b0, 1'b1, 64'h1000, 1'b1, 64'h80);

    clr_logs();
    send_req(HDR_OP_UNLOCK, 64'h1000, 64'h80, 64'h3000);
    wait_rsps("unlock", 1);
    check("unlock_nreq", mlog.size(), 1);
    check_mw("unlock_w0", 0, 1'b0, 1'b1, LA, 1'b1, 64'd0);

    // Next-address computation wraps at 2^64
    clr_logs();
    send_req(HDR_OP_UPDATE, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1, 64'h9000);
    wait_rsps("wrap", 1);
    check_mw("wrap_w0", 0, 1'b0, 1'b1, 64'h0, 1'b1, 64'h9000);

    clr_logs();
    send_req(HDR_OP_NOP, 64'h7000, 64'h1, 64'h2);
    wait_rsps("nop", 1);
    check("nop_nreq", mlog.size(), 0);
    check_rsp("nop", 64'h7000, 64'h1, 64'h2);

    // Memory back-pressure during LOAD
    mem[64'h1000] = 64'h55; mem[64'h1008] = 64'h66;
    clr_logs();
    mem_req_rdy_i = 1'b0;
    send_req(HDR_OP_LOAD, 64'h1000, 64'h0, 64'h0);
    repeat (5) begin
      @(negedge clk);
      check("stall_val", {63'd0, mem_req_val_o}, 64'd1);
      check("stall_addr", mem_req_addr_o, 64'h1000);
    end
    @(posedge clk); #1 mem_req_rdy_i = 1'b1;
    wait_rsps("stall", 1);
    check("stall_nreq", mlog.size(), 2);
    check_rsp("stall", 64'h1000, 64'h55, 64'h66);

    // Response back-pressure blocks new requests
    clr_logs();
    rsp_rdy_i = 1'b0;
    send_req(HDR_OP_ALLOC_INSERT, 64'h1000, 64'h80, 64'h3000);
    w = 0;
    while (!rsp_o.val && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("hold_rsp_seen", {63'd0, rsp_o.val}, 64'd1);
    @(posedge clk); #1;
    req_i.val = 1'b1; req_i.op = HDR_OP_UPDATE; req_i.addr = 64'h4000;
    req_i.size = 64'h1; req_i.next_addr = 64'h2;
    repeat (10) begin
      @(negedge clk);
      check("hold_rsp_val", {63'd0, rsp_o.val}, 64'd1);
      check("hold_req_rdy", {63'd0, req_rdy_o}, 64'd0);
      check("hold_rsp_size", rsp_o.size, 64'h80);
    end
    @(posedge clk); #1;
    req_i = '0;
    rsp_rdy_i = 1'b1;
    wait_rsps("hold", 1);
    check("hold_nreq", mlog.size(), 1);

    // Reset while waiting for memory, then a late memory response
    clr_logs();
    hold_rsp = 1'b1;
    send_req(HDR_OP_LOAD, 64'h1000, 64'h0, 64'h0);
    w = 0;
    while (mlog.size() < 1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0; force_rsp = 1'b1;
    @(posedge clk); #1 force_rsp = 1'b0;
    @(negedge clk);
    check("rstmid_req_rdy", {63'd0, req_rdy_o}, 64'd1);
    check("rstmid_mem_val", {63'd0, mem_req_val_o}, 64'd0);
    check("rstmid_rsp_val", {63'd0, rsp_o.val}, 64'd0);
    repeat (5) @(negedge clk);
    check("rstmid_nrsp", rlog.size(), 0);
    check("rstmid_nreq", mlog.size(), 1);
    hold_rsp = 1'b0;
    mem[64'h1000] = 64'h77; mem[64'h1008] = 64'h88;
    clr_logs();
    send_req(HDR_OP_LOAD, 64'h1000, 64'h0, 64'h0);
    wait_rsps("postrst", 1);
    check_rsp("postrst", 64'h1000, 64'h77, 64'h88);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
